// File: rtl/snake_dir_arbiter_pkg.sv
// Shared encodings for the snake direction arbiter: headings, game states, default IR codes.
package snake_dir_arbiter_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_DOWN  = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_RIGHT = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_OVER  = 2'b11
   } state_t;

   localparam logic [7:0] IR_UP_DEF    = 8'h18;
   localparam logic [7:0] IR_DOWN_DEF  = 8'h52;
   localparam logic [7:0] IR_LEFT_DEF  = 8'h08;
   localparam logic [7:0] IR_RIGHT_DEF = 8'h5A;
   localparam logic [7:0] IR_PAUSE_DEF = 8'h1C;

   // Up/down and left/right differ only in bit 0.
   function automatic dir_t dir_opposite(input dir_t d);
      return dir_t'({d[1], ~d[0]});
   endfunction

endpackage

// File: rtl/snake_dir_arbiter_if.sv
// Input/output bundle between the key/remote front ends, the arbiter and the display.
interface snake_dir_arbiter_if;
   logic [3:0] key_flag;
   logic [3:0] key_value;
   logic       ir_data_en;
   logic [7:0] ir_data;
   logic       game_over;
   logic [1:0] dir;
   logic       step;
   logic [1:0] state;
   logic [1:0] q_level;

   modport master (
      output key_flag, key_value, ir_data_en, ir_data, game_over,
      input  dir, step, state, q_level
   );

   modport slave (
      input  key_flag, key_value, ir_data_en, ir_data, game_over,
      output dir, step, state, q_level
   );
endinterface

// File: rtl/snake_dir_arbiter_dir_fifo2.sv
// Two-entry pending-turn FIFO (dir_fifo2); a same-cycle pop retires the head before the push lands.
module snake_dir_arbiter_dir_fifo2
   import snake_dir_arbiter_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_clr,
   input  logic       i_push,
   input  dir_t       i_din,
   input  logic       i_pop,
   output dir_t       o_head,
   output dir_t       o_tail,
   output logic [1:0] o_level
);

   dir_t       r_mem [2];
   logic [1:0] r_lvl;
   logic [1:0] w_lvl_pop;

   assign w_lvl_pop = r_lvl - {1'b0, i_pop};
   assign o_head    = r_mem[0];
   assign o_tail    = (r_lvl == 2'd2) ? r_mem[1] : r_mem[0];
   assign o_level   = r_lvl;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_lvl    <= 2'd0;
         r_mem[0] <= DIR_RIGHT;
         r_mem[1] <= DIR_RIGHT;
      end else begin
         if (i_pop)
            r_mem[0] <= r_mem[1];
         // Push slot is the level after the pop, so a pop+push at level 1 rewrites slot 0.
         if (i_push)
            r_mem[w_lvl_pop[0]] <= i_din;
         r_lvl <= w_lvl_pop + {1'b0, i_push};
      end
   end

endmodule

// File: rtl/snake_dir_arbiter.sv
// Merges key and IR direction requests, filters illegal turns, queues up to two
// turns and sequences the IDLE/RUN/PAUSE/OVER game states with the step tick.
module snake_dir_arbiter
   import snake_dir_arbiter_pkg::*;
#(
   parameter int         STEP_DIV = 2_500_000,
   parameter logic [7:0] IR_UP    = IR_UP_DEF,
   parameter logic [7:0] IR_DOWN  = IR_DOWN_DEF,
   parameter logic [7:0] IR_LEFT  = IR_LEFT_DEF,
   parameter logic [7:0] IR_RIGHT = IR_RIGHT_DEF,
   parameter logic [7:0] IR_PAUSE = IR_PAUSE_DEF
)(
   input  logic                vga_clk,
   input  logic                sys_rst,
   snake_dir_arbiter_if.slave  bus
);

   localparam int              CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP_DIV - 1);

   logic             r_ir_s1, r_ir_s2, r_ir_s3;
   logic [7:0]       r_ir_code;
   state_t           r_state, w_state_nxt;
   dir_t             r_dir;
   logic             r_step;
   logic [CNT_W-1:0] r_cnt;

   logic       w_ir_edge, w_ir_pause, w_ir_dir_vld;
   dir_t       w_ir_dir, w_key_dir, w_req_dir, w_ref;
   logic [3:0] w_press;
   logic       w_req_vld, w_tick, w_pop, w_push;
   logic       w_cnt_en, w_push_en, w_restart;
   dir_t       w_head, w_tail;
   logic [1:0] w_lvl, w_lvl_pop;

   // ir_data is still stable one cycle after the synchronized rise, so the code is latched then.
   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         r_ir_s1   <= 1'b0;
         r_ir_s2   <= 1'b0;
         r_ir_s3   <= 1'b0;
         r_ir_code <= 8'h00;
      end else begin
         r_ir_s1 <= bus.ir_data_en;
         r_ir_s2 <= r_ir_s1;
         r_ir_s3 <= r_ir_s2;
         if (r_ir_s1 && !r_ir_s2)
            r_ir_code <= bus.ir_data;
      end
   end

   assign w_ir_edge = r_ir_s2 & ~r_ir_s3;

   always_comb begin
      w_ir_dir_vld = 1'b0;
      w_ir_dir     = DIR_RIGHT;
      w_ir_pause   = 1'b0;
      if (w_ir_edge) begin
         case (r_ir_code)
            IR_UP:    begin w_ir_dir_vld = 1'b1; w_ir_dir = DIR_UP;    end
            IR_DOWN:  begin w_ir_dir_vld = 1'b1; w_ir_dir = DIR_DOWN;  end
            IR_LEFT:  begin w_ir_dir_vld = 1'b1; w_ir_dir = DIR_LEFT;  end
            IR_RIGHT: begin w_ir_dir_vld = 1'b1; w_ir_dir = DIR_RIGHT; end
            IR_PAUSE: w_ir_pause = 1'b1;
            default:  ;
         endcase
      end
   end

   assign w_press = bus.key_flag & ~bus.key_value;

   always_comb begin
      w_key_dir = DIR_RIGHT;
      casez (w_press)
         4'b1???: w_key_dir = DIR_UP;
         4'b01??: w_key_dir = DIR_DOWN;
         4'b001?: w_key_dir = DIR_LEFT;
         default: w_key_dir = DIR_RIGHT;
      endcase
   end

   assign w_req_vld = (|w_press) | w_ir_dir_vld;
   assign w_req_dir = (|w_press) ? w_key_dir : w_ir_dir;

   assign w_tick    = w_cnt_en && (r_cnt == TERM);
   assign w_pop     = w_tick && (w_lvl != 2'd0);
   assign w_lvl_pop = w_lvl - {1'b0, w_pop};
   // Reference is the queue tail as it stands after this cycle's pop.
   assign w_ref     = (w_lvl_pop != 2'd0) ? w_tail : (w_pop ? w_head : r_dir);
   assign w_push    = w_push_en && w_req_vld && (w_lvl_pop != 2'd2) &&
                      (w_req_dir != w_ref) && (w_req_dir != dir_opposite(w_ref));

   always_ff @(posedge vga_clk) begin
      if (sys_rst) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_push || w_ir_pause) w_state_nxt = ST_RUN;
         ST_RUN:   if (bus.game_over)        w_state_nxt = ST_OVER;
                   else if (w_ir_pause)      w_state_nxt = ST_PAUSE;
         ST_PAUSE: if (bus.game_over)        w_state_nxt = ST_OVER;
                   else if (w_ir_pause)      w_state_nxt = ST_RUN;
         ST_OVER:  if (w_ir_pause)           w_state_nxt = ST_IDLE;
         default:                            w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_en  = (r_state == ST_RUN);
      w_push_en = (r_state == ST_IDLE) || (r_state == ST_RUN);
      w_restart = (r_state == ST_OVER) && w_ir_pause;
   end

   always_ff @(posedge vga_clk) begin
      if (sys_rst) begin
         r_dir  <= DIR_RIGHT;
         r_step <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_step <= w_tick;
         if (w_restart) begin
            r_dir <= DIR_RIGHT;
            r_cnt <= '0;
         end else begin
            if (w_pop)
               r_dir <= w_head;
            if (w_cnt_en)
               r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   snake_dir_arbiter_dir_fifo2 u_fifo (
      .i_clk   (vga_clk),
      .i_rst   (sys_rst),
      .i_clr   (w_restart),
      .i_push  (w_push),
      .i_din   (w_req_dir),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_tail  (w_tail),
      .o_level (w_lvl)
   );

   assign bus.dir     = r_dir;
   assign bus.step    = r_step;
   assign bus.state   = r_state;
   assign bus.q_level = w_lvl;

endmodule

// File: tb/tb_snake_dir_arbiter.sv
// Directed bench for snake_dir_arbiter: queue-based game model compared every cycle plus literal checkpoints.
module tb_snake_dir_arbiter;

   localparam int SD = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snake_dir_arbiter_if bus();

   snake_dir_arbiter #(.STEP_DIV(SD)) dut (
      .vga_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic chk_en = 1'b0;

   // ---------------- behavioural model ----------------
   logic [1:0] m_dir, m_state;
   logic       m_step;
   int         m_cnt;
   logic [1:0] m_q[$];
   int         m_cyc = 0;
   logic       m_prev_en;
   int         m_due[$];
   logic [7:0] m_code[$];
   logic [7:0] m_c;
   logic [3:0] m_pr;
   logic [1:0] m_rd, m_nd, m_ref, m_ird;
   logic       m_rv, m_irv, m_ipause, m_tick, m_acc;
   int         m_tmp;

   always @(posedge clk) begin
      if (rst) begin
         m_dir = 2'b11; m_state = 2'b00; m_step = 1'b0; m_cnt = 0;
         m_q.delete(); m_due.delete(); m_code.delete(); m_prev_en = 1'b0;
      end else begin
         m_irv = 1'b0; m_ipause = 1'b0; m_ird = 2'b11;
         if (m_due.size() > 0 && m_due[0] == m_cyc) begin
            m_tmp = m_due.pop_front();
            m_c   = m_code.pop_front();
            case (m_c)
               8'h18: begin m_irv = 1'b1; m_ird = 2'b00; end
               8'h52: begin m_irv = 1'b1; m_ird = 2'b01; end
               8'h08: begin m_irv = 1'b1; m_ird = 2'b10; end
               8'h5A: begin m_irv = 1'b1; m_ird = 2'b11; end
               8'h1C: m_ipause = 1'b1;
               default: ;
            endcase
         end
         if (bus.ir_data_en && !m_prev_en) begin
            m_due.push_back(m_cyc + 2);
            m_code.push_back(bus.ir_data);
         end
         m_prev_en = bus.ir_data_en;

         m_pr = bus.key_flag & ~bus.key_value;
         m_rv = 1'b1;
         if      (m_pr[3]) m_rd = 2'b00;
         else if (m_pr[2]) m_rd = 2'b01;
         else if (m_pr[1]) m_rd = 2'b10;
         else if (m_pr[0]) m_rd = 2'b11;
         else begin m_rd = m_ird; m_rv = m_irv; end

         m_tick = (m_state == 2'b01) && (m_cnt == SD - 1);
         m_nd   = m_dir;
         if (m_tick && m_q.size() > 0) m_nd = m_q.pop_front();
         m_ref  = (m_q.size() > 0) ? m_q[m_q.size() - 1] : m_nd;
         m_acc  = (m_state == 2'b00 || m_state == 2'b01) && m_rv && m_q.size() < 2 &&
                  m_rd != m_ref && m_rd != (m_ref ^ 2'b01);
         if (m_acc) m_q.push_back(m_rd);

         if (m_state == 2'b11 && m_ipause) begin
            m_q.delete(); m_cnt = 0; m_dir = 2'b11;
         end else begin
            m_dir = m_nd;
            if (m_state == 2'b01) m_cnt = m_tick ? 0 : m_cnt + 1;
         end
         m_step = m_tick;

         case (m_state)
            2'b00: if (m_acc || m_ipause) m_state = 2'b01;
            2'b01: if (bus.game_over) m_state = 2'b11; else if (m_ipause) m_state = 2'b10;
            2'b10: if (bus.game_over) m_state = 2'b11; else if (m_ipause) m_state = 2'b01;
            default: if (m_ipause) m_state = 2'b00;
         endcase
      end
      m_cyc++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_cmp += 4;
         if (bus.dir !== m_dir) begin
            n_err++; $display("FAIL model_dir cyc=%0d dut=%0d exp=%0d", m_cyc, bus.dir, m_dir);
         end
         if (bus.step !== m_step) begin
            n_err++; $display("FAIL model_step cyc=%0d dut=%0d exp=%0d", m_cyc, bus.step, m_step);
         end
         if (bus.state !== m_state) begin
            n_err++; $display("FAIL model_state cyc=%0d dut=%0d exp=%0d", m_cyc, bus.state, m_state);
         end
         if (int'(bus.q_level) != m_q.size()) begin
            n_err++; $display("FAIL model_qlvl cyc=%0d dut=%0d exp=%0d", m_cyc, bus.q_level, m_q.size());
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic lit(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      bus.key_flag = k; bus.key_value = ~k;
      tick();
      bus.key_flag = 4'h0; bus.key_value = 4'hF;
   endtask

   // Rise at E1, held through E2; the edge acts at E3 together with key k / game_over go.
   task automatic ir_send(input logic [7:0] code, input logic [3:0] k, input logic go);
      bus.ir_data = code; bus.ir_data_en = 1'b1;
      tick(); tick();
      bus.ir_data_en = 1'b0;
      bus.key_flag = k; bus.key_value = ~k; bus.game_over = go;
      tick();
      bus.key_flag = 4'h0; bus.key_value = 4'hF; bus.game_over = 1'b0;
   endtask

   task automatic wait_step();
      int n;
      n = 0;
      do begin tick(); n++; end while (!bus.step && n < 5 * SD);
      if (!bus.step) begin
         n_cmp++; n_err++;
         $display("FAIL step_timeout waited=%0d cycles exp=step pulse", n);
      end
   endtask

   int cnt_steps;
   int gap;

   initial begin
      bus.key_flag = 4'h0; bus.key_value = 4'hF;
      bus.ir_data_en = 1'b0; bus.ir_data = 8'h00; bus.game_over = 1'b0;
      rst = 1'b1;
      tick();
      chk_en = 1'b1;
      tick(); tick();
      rst = 1'b0;

      // Idle for 10 step periods
      cnt_steps = 0;
      repeat (10 * SD) begin tick(); if (bus.step) cnt_steps++; end
      lit("idle_steps", cnt_steps, 0);
      lit("idle_state", int'(bus.state), 0);
      lit("idle_dir", int'(bus.dir), 3);
      lit("idle_qlvl", int'(bus.q_level), 0);

      // Start with up
      press(4'b1000);
      lit("start_state", int'(bus.state), 1);
      lit("start_qlvl", int'(bus.q_level), 1);
      repeat (SD - 1) tick();
      lit("first_step_early", int'(bus.step), 0);
      tick();
      lit("first_step", int'(bus.step), 1);
      lit("first_step_dir", int'(bus.dir), 0);
      lit("first_step_qlvl", int'(bus.q_level), 0);

      // Reverse rejected, then two queued turns
      press(4'b0100);
      lit("reverse_rej_qlvl", int'(bus.q_level), 0);
      press(4'b0010);
      press(4'b0100);
      lit("two_turns_qlvl", int'(bus.q_level), 2);
      wait_step();
      lit("turn1_dir", int'(bus.dir), 2);
      lit("turn1_qlvl", int'(bus.q_level), 1);
      wait_step();
      lit("turn2_dir", int'(bus.dir), 1);

      // Key left beats IR_RIGHT in the same cycle; third turn dropped
      ir_send(8'h5A, 4'b0010, 1'b0);
      lit("arb_qlvl", int'(bus.q_level), 1);
      press(4'b1000);
      press(4'b0001);
      lit("full_drop_qlvl", int'(bus.q_level), 2);
      wait_step();
      lit("arb_dir", int'(bus.dir), 2);
      wait_step();
      lit("arb_dir2", int'(bus.dir), 0);

      // IR-only turn, then an unknown code
      ir_send(8'h08, 4'h0, 1'b0);
      lit("ir_turn_qlvl", int'(bus.q_level), 1);
      ir_send(8'h77, 4'h0, 1'b0);
      lit("ir_unknown_qlvl", int'(bus.q_level), 1);
      wait_step();
      lit("ir_turn_dir", int'(bus.dir), 2);

      // Pause at count 3, resume needs SD-3 more cycles
      ir_send(8'h1C, 4'h0, 1'b0);
      lit("pause_state", int'(bus.state), 2);
      cnt_steps = 0;
      repeat (20) begin tick(); if (bus.step) cnt_steps++; end
      lit("pause_steps", cnt_steps, 0);
      press(4'b1000);
      lit("pause_key_qlvl", int'(bus.q_level), 0);
      ir_send(8'h1C, 4'h0, 1'b0);
      lit("resume_state", int'(bus.state), 1);
      gap = 0;
      do begin tick(); gap++; end while (!bus.step && gap < 4 * SD);
      lit("resume_gap", gap, SD - 3);

      // game_over wins over IR_PAUSE; then restart
      press(4'b1000);
      ir_send(8'h1C, 4'h0, 1'b1);
      lit("over_state", int'(bus.state), 3);
      lit("over_qlvl", int'(bus.q_level), 1);
      repeat (3) tick();
      ir_send(8'h1C, 4'h0, 1'b0);
      lit("restart_state", int'(bus.state), 0);
      lit("restart_dir", int'(bus.dir), 3);
      lit("restart_qlvl", int'(bus.q_level), 0);

      // Reset mid-run drops a pending IR edge
      press(4'b1000);
      lit("rerun_state", int'(bus.state), 1);
      bus.ir_data = 8'h1C; bus.ir_data_en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.ir_data_en = 1'b0;
      repeat (6) tick();
      lit("rst_state", int'(bus.state), 0);
      lit("rst_dir", int'(bus.dir), 3);
      lit("rst_qlvl", int'(bus.q_level), 0);
      lit("rst_step", int'(bus.step), 0);

      repeat (2) tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
